ac_snoop_arbiter: RTL and testbench

- Round-robin arbiter that picks one pending snoop request among 2*N_MASTERS sources and drives the snoop address channel handshake.
- Sources are N_MASTERS read-triggered requesters and N_MASTERS write-triggered requesters.
- Produces the registered one-hot mux_sel that the downstream AC signal mux uses to select ACADDR/ACSNOOP/ACPROT.
- Owns ACVALID toward the snooped cache, and returns a per-source acknowledge when ACVALID/ACREADY complete.

---
 rtl/ac_snoop_arbiter.sv | 97 +++++++++
 tb/tb_ac_snoop_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ac_snoop_arbiter.sv
// Round-robin snoop arbiter over N read-triggered and N write-triggered sources.
// It owns ACVALID and the registered one-hot select for the AC signal mux.
module ac_snoop_arbiter #(
  parameter int N_MASTERS    = 8,
  parameter int RR_RESET_PTR = 0
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [N_MASTERS-1:0]   snoop_req_rd,
  input  logic [N_MASTERS-1:0]   snoop_req_wr,
  input  logic                   ACREADY,
  output logic                   ACVALID,
  output logic [2*N_MASTERS-1:0] mux_sel,
  output logic [2*N_MASTERS-1:0] snoop_ack,
  output logic                   busy
);
  localparam int NS = 2 * N_MASTERS;
  localparam int PW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [NS-1:0] req, cand;
  logic [PW-1:0] rr_ptr, grant_idx, scan_base, pick_idx;
  logic          pick_vld, hs;

  function automatic logic [PW-1:0] inc_idx(input logic [PW-1:0] i);
    return (int'(i) == NS - 1) ? '0 : i + 1'b1;
  endfunction

  assign req  = {snoop_req_wr, snoop_req_rd};
  assign hs   = (state == GRANT) && ACREADY;
  assign busy = ACVALID;

  // On a handshake the source has not yet seen its ack, so its bit is masked
  // and the scan starts just past it, allowing a bubble-free next grant.
  always_comb begin
    int j;
    j         = 0;
    cand      = req;
    scan_base = rr_ptr;
    if (hs) begin
      cand      = req & ~mux_sel;
      scan_base = inc_idx(grant_idx);
    end
    pick_vld = 1'b0;
    pick_idx = '0;
    // Scan high offset to low so the lowest offset from scan_base wins.
    for (int k = NS - 1; k >= 0; k--) begin
      j = int'(scan_base) + k;
      if (j >= NS) j = j - NS;
      if (cand[j]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(j);
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      ACVALID   <= 1'b0;
      mux_sel   <= '0;
      snoop_ack <= '0;
      rr_ptr    <= PW'(RR_RESET_PTR);
      grant_idx <= '0;
    end else begin
      snoop_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= GRANT;
            ACVALID   <= 1'b1;
            mux_sel   <= {{(NS-1){1'b0}}, 1'b1} << pick_idx;
            grant_idx <= pick_idx;
          end
        end
        GRANT: begin
          // Grant is held until ACREADY; dropped reqs cannot withdraw it.
          if (ACREADY) begin
            snoop_ack <= mux_sel;
            rr_ptr    <= inc_idx(grant_idx);
            if (pick_vld) begin
              mux_sel   <= {{(NS-1){1'b0}}, 1'b1} << pick_idx;
              grant_idx <= pick_idx;
            end else begin
              state   <= IDLE;
              ACVALID <= 1'b0;
              mux_sel <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ac_snoop_arbiter.sv
// Directed bench for ac_snoop_arbiter: latency, stall, round-robin order,
// wrap-around, stale-request masking and asynchronous reset.
module tb_ac_snoop_arbiter;
  localparam int N = 8;

  logic          ACLK, ARESET, ACREADY;
  logic [2*N-1:0] req;
  logic [N-1:0]  snoop_req_rd, snoop_req_wr;
  logic          ACVALID, busy;
  logic [2*N-1:0] mux_sel, snoop_ack;

  int total = 0;
  int bad   = 0;

  assign snoop_req_rd = req[N-1:0];
  assign snoop_req_wr = req[2*N-1:N];

  ac_snoop_arbiter #(.N_MASTERS(N), .RR_RESET_PTR(0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .snoop_req_rd(snoop_req_rd), .snoop_req_wr(snoop_req_wr),
    .ACREADY(ACREADY), .ACVALID(ACVALID),
    .mux_sel(mux_sel), .snoop_ack(snoop_ack), .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] ms,
                         input logic [15:0] ack);
    check({tag, ".vld"},  {31'd0, ACVALID}, {31'd0, v});
    check({tag, ".busy"}, {31'd0, busy},    {31'd0, v});
    check({tag, ".sel"},  {16'd0, mux_sel}, {16'd0, ms});
    check({tag, ".ack"},  {16'd0, snoop_ack}, {16'd0, ack});
  endtask

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  initial begin
    ARESET = 1'b1; req = '0; ACREADY = 1'b0;
    repeat (2) @(negedge ACLK);
    chk_out("reset", 1'b0, 16'h0, 16'h0);
    ARESET = 1'b0;

    // single request, one-cycle latency, ack then idle
    req = 16'h0001; ACREADY = 1'b1;
    tick(); chk_out("t1.grant", 1'b1, 16'h0001, 16'h0);
    tick(); chk_out("t1.ack",   1'b0, 16'h0,    16'h0001);
    req = 16'h0000;
    tick(); chk_out("t1.idle",  1'b0, 16'h0,    16'h0);

    // pointer now at 1: index 1 wins over 0, then 0 back-to-back
    req = 16'h0003;
    tick(); chk_out("ptr.grant", 1'b1, 16'h0002, 16'h0);
    tick(); chk_out("ptr.b2b",   1'b1, 16'h0001, 16'h0002);
    req = 16'h0001;
    tick(); chk_out("ptr.ack",   1'b0, 16'h0,    16'h0001);
    req = 16'h0000;

    // stall: grant held while ACREADY low, even after req drops
    ACREADY = 1'b0; req = 16'h0100;
    tick();
    for (int c = 1; c <= 6; c++) begin
      chk_out($sformatf("stall%0d", c), 1'b1, 16'h0100, 16'h0);
      if (c == 2) req = 16'h0000;
      if (c == 6) ACREADY = 1'b1;
      tick();
    end
    chk_out("stall.ack",  1'b0, 16'h0, 16'h0100);
    tick(); chk_out("stall.idle", 1'b0, 16'h0, 16'h0);

    // reset pointer back to 0, then full round-robin sweep
    ARESET = 1'b1; tick(); ARESET = 1'b0;
    req = 16'hFFFF;
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("rr%0d.sel", k), {16'd0, mux_sel}, 32'(1) << k);
      check($sformatf("rr%0d.vld", k), {31'd0, ACVALID}, 32'd1);
      if (k == 15) req[0] = 1'b1;
      tick();
      check($sformatf("rr%0d.ack", k), {16'd0, snoop_ack}, 32'(1) << k);
      req[k] = 1'b0;
    end
    chk_out("rr17", 1'b1, 16'h0001, 16'h8000);
    tick(); chk_out("rr17.ack", 1'b0, 16'h0, 16'h0001);
    req = 16'h0000;

    // wrap-around: grant 14 so pointer is 15, then 0x8001
    req = 16'h4000;
    tick(); chk_out("wrap.g14", 1'b1, 16'h4000, 16'h0);
    tick(); chk_out("wrap.a14", 1'b0, 16'h0,    16'h4000);
    req = 16'h8001;
    tick(); chk_out("wrap.g15", 1'b1, 16'h8000, 16'h0);
    tick(); chk_out("wrap.g0",  1'b1, 16'h0001, 16'h8000);
    req = 16'h0001;
    tick(); chk_out("wrap.a0",  1'b0, 16'h0,    16'h0001);
    req = 16'h0000;

    // masking: req held through its ack cycle gives exactly one more grant
    req = 16'h0004;
    tick(); chk_out("mask.g1", 1'b1, 16'h0004, 16'h0);
    tick(); chk_out("mask.a1", 1'b0, 16'h0,    16'h0004);
    tick(); chk_out("mask.g2", 1'b1, 16'h0004, 16'h0);
    req = 16'h0000;
    tick(); chk_out("mask.a2", 1'b0, 16'h0,    16'h0004);
    tick(); chk_out("mask.end", 1'b0, 16'h0,   16'h0);

    // asynchronous reset mid-grant; pointer (was 3) returns to 0
    req = 16'h0020; ACREADY = 1'b0;
    tick(); chk_out("amid.grant", 1'b1, 16'h0020, 16'h0);
    #1 ARESET = 1'b1;
    #1 chk_out("amid.clear", 1'b0, 16'h0, 16'h0);
    @(negedge ACLK);
    ARESET = 1'b0; req = 16'h0009; ACREADY = 1'b1;
    tick(); chk_out("amid.g0", 1'b1, 16'h0001, 16'h0);
    tick(); chk_out("amid.g3", 1'b1, 16'h0008, 16'h0001);
    req = 16'h0008;
    tick(); chk_out("amid.a3", 1'b0, 16'h0,    16'h0008);
    req = 16'h0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
